// File: rtl/hc_csr_bank.sv
// hc_csr_bank
// MMIO control/status register bank for a HardCloud accelerator. Decodes
// CCI-P MMIO writes into the DSM base, control and buffer descriptor
// registers, answers in-window MMIO reads one cycle later, and runs the
// accelerator run-control state machine with a saturating run-cycle counter.
//
// Register map (byte offsets from CSR_BASE):
//   0x00 STATUS (RO)  [1:0] state code
//   0x08 CYCLES (RO)  run-cycle counter, zero-extended
//   0x10 DSM_BASE (RW)
//   0x18 CONTROL (WO, reads 0)
//   0x20+0x10*i BUF_ADDR[i] (RW), 0x28+0x10*i BUF_SIZE[i] (RW, 32 bit)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mmio_rx_*           c0 Rx MMIO request: write/read valid, dword address,
//                       length (0 = 4 B, 1 = 8 B), tid, data
//   mmio_tx_*           c2 Tx MMIO read response: valid, tid, data
//   acc_done            accelerator finished (only looked at while running)
//   acc_reset           accelerator soft reset, high in S_RESET
//   acc_start           one-cycle pulse on entry to S_RUN
//   acc_running         high in S_RUN
//   dsm_base            DSM base byte address
//   buf_addr, buf_size  buffer descriptors, packed, buffer i at slice i
module hc_csr_bank #(
  parameter int          NUM_BUFFERS = 2,
  parameter logic [15:0] CSR_BASE    = 16'h100,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mmio_rx_wr_valid,
  input  logic                      mmio_rx_rd_valid,
  input  logic [15:0]               mmio_rx_address,
  input  logic [1:0]                mmio_rx_length,
  input  logic [8:0]                mmio_rx_tid,
  input  logic [63:0]               mmio_rx_data,
  output logic                      mmio_tx_rd_valid,
  output logic [8:0]                mmio_tx_tid,
  output logic [63:0]               mmio_tx_data,
  input  logic                      acc_done,
  output logic                      acc_reset,
  output logic                      acc_start,
  output logic                      acc_running,
  output logic [63:0]               dsm_base,
  output logic [64*NUM_BUFFERS-1:0] buf_addr,
  output logic [32*NUM_BUFFERS-1:0] buf_size
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Window bounds in 32-bit word units, matching the header address.
  localparam logic [31:0] WIN_LO_W = {16'd0, CSR_BASE} >> 2;
  localparam logic [31:0] WIN_HI_W =
    ({16'd0, CSR_BASE} + 32'h20 + 32'(NUM_BUFFERS) * 32'h10) >> 2;

  localparam logic [5:0] REG_STATUS  = 6'd0;
  localparam logic [5:0] REG_CYCLES  = 6'd1;
  localparam logic [5:0] REG_DSM     = 6'd2;
  localparam logic [5:0] REG_CONTROL = 6'd3;

  state_t                 state, state_next;
  logic                   start_now;
  logic [CNT_WIDTH-1:0]   cycles;
  logic [63:0]            buf_addr_q [NUM_BUFFERS];
  logic [31:0]            buf_size_q [NUM_BUFFERS];

  logic [31:0] word_addr;
  logic [6:0]  word_off;
  logic        in_window;
  logic [5:0]  reg_idx;
  logic        dword_hi;
  logic        len64, len32;
  logic        wr_lo, wr_hi;
  logic [31:0] hi_data;
  logic        cmd_valid;
  logic [31:0] cmd;
  logic [63:0] rd_data;

  // Address decode. word_off is only meaningful inside the window, which
  // is at most 72 words wide, so 7 bits suffice.
  assign word_addr = {16'd0, mmio_rx_address};
  assign in_window = (word_addr >= WIN_LO_W) && (word_addr < WIN_HI_W);
  assign word_off  = 7'(word_addr - WIN_LO_W);
  assign reg_idx   = word_off[6:1];
  assign dword_hi  = word_off[0];
  assign len64     = (mmio_rx_length == 2'd1);
  assign len32     = (mmio_rx_length == 2'd0);

  // A misaligned 64-bit write touches neither half and is dropped.
  assign wr_lo = mmio_rx_wr_valid && in_window && !dword_hi && (len64 || len32);
  assign wr_hi = mmio_rx_wr_valid && in_window &&
                 ((len64 && !dword_hi) || (len32 && dword_hi));

  // A 32-bit write always carries its payload in data[31:0].
  assign hi_data = len64 ? mmio_rx_data[63:32] : mmio_rx_data[31:0];

  assign cmd_valid = wr_lo && (reg_idx == REG_CONTROL);
  assign cmd       = mmio_rx_data[31:0];

  // Run-control next state. A legal command beats acc_done in the same cycle.
  always_comb begin
    state_next = state;
    if (cmd_valid && cmd == 32'h0) begin
      state_next = S_RESET;
    end else if (cmd_valid && cmd == 32'h1 && state == S_RESET) begin
      state_next = S_READY;
    end else if (cmd_valid && cmd == 32'h3 && (state == S_READY || state == S_DONE)) begin
      state_next = S_RUN;
    end else if (cmd_valid && cmd == 32'h7 && state == S_RUN) begin
      state_next = S_READY;
    end else if (state == S_RUN && acc_done) begin
      state_next = S_DONE;
    end
  end

  assign start_now   = (state_next == S_RUN) && (state != S_RUN);
  assign acc_reset   = (state == S_RESET);
  assign acc_running = (state == S_RUN);

  // Counter counts every cycle spent in S_RUN, including the one where
  // acc_done is seen, and is cleared only by a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RESET;
      acc_start <= 1'b0;
      cycles    <= '0;
    end else begin
      state     <= state_next;
      acc_start <= start_now;
      if (start_now) begin
        cycles <= '0;
      end else if (state == S_RUN && cycles != '1) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsm_base <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_addr_q[i] <= '0;
        buf_size_q[i] <= '0;
      end
    end else begin
      if (wr_lo && reg_idx == REG_DSM) dsm_base[31:0]  <= mmio_rx_data[31:0];
      if (wr_hi && reg_idx == REG_DSM) dsm_base[63:32] <= hi_data;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (wr_lo && reg_idx == 6'(4 + 2 * i)) buf_addr_q[i][31:0]  <= mmio_rx_data[31:0];
        if (wr_hi && reg_idx == 6'(4 + 2 * i)) buf_addr_q[i][63:32] <= hi_data;
        // BUF_SIZE has no upper half, so only the low-half write matters.
        if (wr_lo && reg_idx == 6'(5 + 2 * i)) buf_size_q[i]        <= mmio_rx_data[31:0];
      end
    end
  end

  // Read mux sees register values before any write landing this cycle.
  always_comb begin
    rd_data = 64'd0;
    if (reg_idx == REG_STATUS) rd_data = {62'd0, state};
    if (reg_idx == REG_CYCLES) rd_data = 64'(cycles);
    if (reg_idx == REG_DSM)    rd_data = dsm_base;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (reg_idx == 6'(4 + 2 * i)) rd_data = buf_addr_q[i];
      if (reg_idx == 6'(5 + 2 * i)) rd_data = {32'd0, buf_size_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_tx_rd_valid <= 1'b0;
      mmio_tx_tid      <= '0;
      mmio_tx_data     <= '0;
    end else begin
      mmio_tx_rd_valid <= mmio_rx_rd_valid && in_window;
      if (mmio_rx_rd_valid && in_window) begin
        mmio_tx_tid  <= mmio_rx_tid;
        mmio_tx_data <= rd_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_pack
    assign buf_addr[64*g +: 64] = buf_addr_q[g];
    assign buf_size[32*g +: 32] = buf_size_q[g];
  end

endmodule

// File: doc/hc_csr_bank.md
# hc_csr_bank

Parametrised MMIO control/status register bank for HardCloud accelerators, sitting between the CCI-P MMIO channels (c0 Rx requests, c2 Tx read responses) and the accelerator datapath. It decodes writes to the DSM base, control and an arbitrary number of buffer descriptor registers, and answers MMIO reads. It also runs the accelerator run-control state machine with a run-cycle counter and status register. It generalises the fixed two-buffer, write-only decode used by earlier samples.

## Interface
- NUM_BUFFERS, 2: number of buffer descriptors, 1..16.
- CSR_BASE, 16'h100: byte address of the first register in the window.
- CNT_WIDTH, 32: run-cycle counter width, saturating.
- clk  in  1  CCI-P clock.
- reset  in  1  synchronous, active-high; all state returns to reset values on the next edge.
- mmio_rx  in  t_if_ccip_c0_Rx  MMIO requests (mmioWrValid, mmioRdValid, hdr, data).
- mmio_tx  out  t_if_ccip_c2_Tx  MMIO read response (mmioRdValid, hdr.tid, data).
- acc_done  in  1  accelerator finished; sampled only in S_RUN.
- acc_reset  out  1  accelerator soft reset, high in S_RESET.
- acc_start  out  1  one-cycle pulse on entry to S_RUN.
- acc_running  out  1  high in S_RUN.
- dsm_base  out  64  DSM base byte address.
- buf_addr  out  NUM_BUFFERS x 64  buffer base addresses.
- buf_size  out  NUM_BUFFERS x 32  buffer sizes in bytes.

## Operation
- Byte-address map relative to CSR_BASE:
  - +0x00 STATUS (RO): [1:0] state code, RESET=0, READY=1, RUN=2, DONE=3; [63:2]=0.
  - +0x08 CYCLES (RO): run-cycle counter, zero-extended.
  - +0x10 DSM_BASE (RW).
  - +0x18 CONTROL (WO; reads return 0).
  - +0x20+0x10*i BUF_ADDR[i] (RW).
  - +0x28+0x10*i BUF_SIZE[i] (RW, 32 bits, upper read bits 0).
- Header address is in 32-bit words: byte address = hdr.address << 2. The window is [CSR_BASE, CSR_BASE+0x20+0x10*NUM_BUFFERS).
- Out-of-window writes are ignored. Out-of-window reads get no response; another block owns them.
- Write width comes from hdr.length:
  - 64-bit writes to an 8-byte-aligned register update all of it.
  - 32-bit writes at dword offset 0 update [31:0].
  - 32-bit writes at dword offset 1 update [63:32]; for BUF_SIZE this is ignored.
- Writes to RO registers are ignored.
- CONTROL FSM, driven by the written value in data[31:0]:
  - 0x0 from any state -> S_RESET.
  - 0x1 in S_RESET -> S_READY.
  - 0x3 in S_READY or S_DONE -> S_RUN; clears CYCLES and pulses acc_start.
  - 0x7 in S_RUN -> S_READY.
  - acc_done=1 in S_RUN -> S_DONE.
  - Any other value, or a code that is not legal in the current state, is ignored.
- Simultaneous acc_done and a 0x7 write in S_RUN: the write wins -> S_READY.
- Simultaneous acc_done and a 0x0 write in S_RUN: -> S_RESET.
- CYCLES increments by 1 each cycle in S_RUN and saturates at all-ones. It holds in the other states and clears only on a start or on reset.
- Reset values: state S_RESET, acc_reset=1, acc_start=0, acc_running=0, all registers 0, mmio_tx.mmioRdValid=0, CYCLES=0.

## Timing
- Write-to-output: a register written in cycle N is visible on dsm_base/buf_*/state outputs in cycle N+1.
- acc_start is high exactly in cycle N+1 after the accepted start write.
- Read response: mmio_tx.mmioRdValid is registered, high in cycle N+1 for an in-window read in cycle N. It carries hdr.tid equal to the request tid and the 64-bit register value as of cycle N, before any same-cycle write.
- One read response per cycle; CCI-P reads arrive at most one per cycle, so no buffering is needed.
- Read-during-write to the same register returns the old value.
- acc_done in cycle N moves the state at edge N+1. CYCLES counts the cycle in which acc_done is seen.
- reset asserted mid-run: the next cycle gives S_RESET, acc_running=0, and any pending read response is dropped.

## Test plan
- Reset, then read +0x00 tid=5 -> response in the next cycle with tid=5, data=0. acc_reset=1.
- 64-bit write 0xDEAD_BEEF_0000_1000 to +0x20+0x10 (NUM_BUFFERS=4) -> buf_addr[1] equals it the next cycle. A 32-bit write 0x1 at dword offset 1 -> upper becomes 0x1, lower unchanged.
- CONTROL 1 then 3 -> acc_start is a single one-cycle pulse. After 10 cycles with acc_done=1 -> STATUS=3 and CYCLES=11.
- CONTROL 7 in the same cycle as acc_done -> STATUS=1. CONTROL 3 from S_RESET is ignored (STATUS stays 0).
- CNT_WIDTH=4, run 20 cycles -> CYCLES=15, saturated.
- Read at CSR_BASE+0x20+0x10*NUM_BUFFERS -> no response. Write there -> no register changes. Reset mid-run -> S_RESET and outputs at reset values the next cycle.
